sfifo_ctrl: RTL and testbench
=============================

# sfifo_ctrl

Synchronous FIFO control and read port wrapped around the team's `fifo_data` storage array. It owns the write and read pointers, occupancy, and full/almost-full flags. It presents the consumer side as a valid/ready stream, so downstream blocks pop words without handling pointers themselves. It sits between any pointer-free producer (push/full) and a ready/valid consumer.

## Interface
- `WIDTH`, 16, data word width in bits
- `DEPTH_BITS`, 3, log2 of storage depth
- `DEPTH`, `1 << DEPTH_BITS`, storage entries (derived; not overridden)
- `AFULL_LVL`, `DEPTH-2`, storage occupancy at or above which `afull` asserts
- `clk`  in  1  single clock; all state updates on the rising edge
- `rstn`  in  1  reset, asynchronous assert, active-low
- `wr`  in  1  push request; `din` is captured when `wr & ~full`
- `din`  in  WIDTH  write data
- `full`  out  1  storage holds DEPTH words
- `afull`  out  1  storage occupancy >= AFULL_LVL
- `ovf`  out  1  sticky: a push was attempted while `full`
- `rd_valid`  out  1  `dout` holds a valid head word
- `rd_ready`  in  1  consumer accepts; pop = `rd_valid & rd_ready`
- `dout`  out  WIDTH  head-of-queue word
- `count`  out  DEPTH_BITS+1  total words held, including the output register when present

## Operation
- Pointers `wptr` and `rptr` are DEPTH_BITS wide and wrap modulo DEPTH with no special case.
- Storage occupancy `scnt` is a DEPTH_BITS+1 register: +1 on accepted push, −1 on storage read, unchanged when both or neither occur.
- `full = (scnt == DEPTH)`. A push while `full` is dropped, even if a pop occurs in the same cycle. The drop sets `ovf`, which clears only on reset.
- Accepted push: `fifo_data` is written at `wptr`, then `wptr` increments.
- Storage read: `rptr` increments.
- Simultaneous push and pop on a non-full FIFO: both take effect; `scnt` holds.
- Pop while `rd_valid = 0`: ignored; no state changes.
- `dout` is don't-care while `rd_valid = 0` and must be held stable while `rd_valid & ~rd_ready`.

## Timing
- Reset (asynchronous, applies mid-operation too): pointers 0, `scnt` 0, `full` 0, `afull` 0 (unless AFULL_LVL = 0, then 1), `ovf` 0, `rd_valid` 0, `count` 0. Storage contents are not reset.
- Flags `full`, `afull`, `count`, `rd_valid` are registered or decoded from registers. They update in the cycle after the causing edge, never combinationally from `wr` or `rd_ready`.
- Write-to-`rd_valid` latency from empty: 1 cycle without SFIFO_OREG_EN, 2 cycles with it.
- Throughput: one push and one pop per cycle sustained, in both configurations.

## Configuration
- `SFIFO_OREG_EN` undefined:
  - `dout` is the combinational storage output at `rptr`.
  - `rd_valid = (scnt != 0)`; a pop is the storage read.
  - `count = scnt`; maximum capacity DEPTH.
  - `dout` value under reset is X.
- `SFIFO_OREG_EN` defined:
  - A WIDTH-bit output register with a valid bit drives `dout` and `rd_valid`.
  - The register loads from storage (a storage read) when it is empty or being popped in the same cycle, and `scnt != 0`.
  - `count = scnt + oreg_valid`; capacity DEPTH+1. `full` and `afull` still refer to storage only.
  - `dout` resets to 0.

## Structure
- A shared package `sfifo_pkg` holds a pointer-width helper function and the default constants (WIDTH, DEPTH_BITS).
- One sub-module instance: `fifo_data`, parameterized with WIDTH and DEPTH_BITS and driven by `wptr`, `rptr`, push-enable and `din`.
- Control, flags and the optional output register live in this module.

## Test plan
- Reset, then 8 pushes of 0x0001..0x0008 with `rd_ready = 0`:
  - `full = 1` after the 8th push; `afull` rises after the 6th.
  - `count` reaches 8 (9 cannot occur without a pop).
  - `dout = 0x0001`, held stable.
- Push 0x00AA while `full` with a same-cycle pop: word dropped, `ovf = 1`, `count` = 7. The data order read out excludes 0x00AA.
- Empty FIFO, single push of 0x1234: `rd_valid` rises 1 cycle later (2 with SFIFO_OREG_EN) with `dout = 0x1234`. Pop returns `count` to 0.
- Continuous push and pop for 20 cycles with an incrementing pattern: output matches input order across two pointer wraps, and `count` stays constant.
- Assert `rstn` low mid-stream with 5 words held: all outputs return to reset values asynchronously, and earlier data never reappears after release.
- Random `rd_ready` backpressure over 200 cycles: `dout` stable whenever `rd_valid & ~rd_ready`, and the scoreboard shows no loss or duplication.

Source files
------------

// File: rtl/sfifo_pkg.sv
// sfifo_pkg
//   Shared constants and helpers for the synchronous FIFO controller
//   (sfifo_ctrl) and its storage array (fifo_data).
//   Contents:
//     SFIFO_WIDTH       default data word width
//     SFIFO_DEPTH_BITS  default log2 of storage depth
//     ptr_width()       address/pointer width needed to index 'depth' entries
package sfifo_pkg;

  localparam int SFIFO_WIDTH      = 16;
  localparam int SFIFO_DEPTH_BITS = 3;

  // A single-entry store still needs a 1-bit pointer so that vectors stay legal.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_data.sv
// fifo_data
//   Storage array for the synchronous FIFO. Synchronous write, combinational
//   read. Contents are deliberately not reset.
//   Ports:
//     clk    in   clock; writes occur on the rising edge
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  word currently stored at raddr
module fifo_data
  import sfifo_pkg::*;
#(
  parameter int WIDTH      = SFIFO_WIDTH,
  parameter int DEPTH_BITS = SFIFO_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int ENTRIES = 1 << DEPTH_BITS;

  logic [WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sfifo_ctrl.sv
// sfifo_ctrl
//   Synchronous FIFO control wrapped around fifo_data. Owns the write/read
//   pointers, storage occupancy and the full/almost-full/overflow flags, and
//   presents the consumer side as a valid/ready stream.
//   Optional feature macro: SFIFO_OREG_EN
//     undefined: dout comes straight from storage at rptr (1-cycle latency)
//     defined:   a registered output stage with its own valid bit drives
//                dout/rd_valid (2-cycle latency, capacity DEPTH+1)
//   Ports:
//     clk       in   single clock, rising edge
//     rstn      in   asynchronous active-low reset
//     wr        in   push request; din captured when wr & ~full
//     din       in   write data
//     full      out  storage holds DEPTH words
//     afull     out  storage occupancy >= AFULL_LVL
//     ovf       out  sticky: push attempted while full
//     rd_valid  out  dout holds a valid head word
//     rd_ready  in   consumer accepts; pop = rd_valid & rd_ready
//     dout      out  head-of-queue word
//     count     out  total words held (storage plus output register)
module sfifo_ctrl
  import sfifo_pkg::*;
#(
  parameter int WIDTH      = SFIFO_WIDTH,
  parameter int DEPTH_BITS = SFIFO_DEPTH_BITS,
  parameter int AFULL_LVL  = (1 << DEPTH_BITS) - 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  output logic                  afull,
  output logic                  ovf,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_BITS:0]   count
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int PW    = ptr_width(DEPTH);

  localparam logic [DEPTH_BITS:0] FULL_CNT  = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AFULL_CNT = (DEPTH_BITS + 1)'(AFULL_LVL);

  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [DEPTH_BITS:0] scnt_q, scnt_d;
  logic                ovf_q, ovf_d;

  logic                push;
  logic                sread;
  logic                s_nonempty;
  logic [WIDTH-1:0]    mem_rdata;

  assign full       = (scnt_q == FULL_CNT);
  assign afull      = (scnt_q >= AFULL_CNT);
  assign ovf        = ovf_q;
  assign s_nonempty = (scnt_q != '0);

  // A push while full is dropped even when a pop frees a slot this cycle,
  // so acceptance depends only on the registered occupancy.
  assign push = wr & ~full;

  fifo_data #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo_data (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (din),
    .raddr (rptr_q),
    .rdata (mem_rdata)
  );

`ifdef SFIFO_OREG_EN
  logic             oreg_valid_q, oreg_valid_d;
  logic [WIDTH-1:0] oreg_data_q, oreg_data_d;

  // Refill the output register whenever it is empty or draining this cycle,
  // which keeps one pop per cycle sustainable.
  assign sread = (~oreg_valid_q | rd_ready) & s_nonempty;

  always_comb begin
    oreg_valid_d = oreg_valid_q;
    oreg_data_d  = oreg_data_q;
    if (sread) begin
      oreg_valid_d = 1'b1;
      oreg_data_d  = mem_rdata;
    end else if (rd_ready) begin
      oreg_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      oreg_valid_q <= 1'b0;
      oreg_data_q  <= '0;
    end else begin
      oreg_valid_q <= oreg_valid_d;
      oreg_data_q  <= oreg_data_d;
    end
  end

  assign rd_valid = oreg_valid_q;
  assign dout     = oreg_data_q;
  assign count    = scnt_q + {{DEPTH_BITS{1'b0}}, oreg_valid_q};
`else
  // Without an output stage a pop is the storage read itself.
  assign sread    = rd_ready & s_nonempty;
  assign rd_valid = s_nonempty;
  assign dout     = mem_rdata;
  assign count    = scnt_q;
`endif

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    scnt_d = scnt_q;
    ovf_d  = ovf_q | (wr & full);
    if (push)  wptr_d = wptr_q + 1'b1;
    if (sread) rptr_d = rptr_q + 1'b1;
    case ({push, sread})
      2'b10:   scnt_d = scnt_q + 1'b1;
      2'b01:   scnt_d = scnt_q - 1'b1;
      default: scnt_d = scnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      scnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      scnt_q <= scnt_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sfifo_ctrl.sv
// tb_sfifo_ctrl
//   Directed and randomized-backpressure bench for sfifo_ctrl in its default
//   build (SFIFO_OREG_EN undefined). Inputs change 1 time unit after each
//   rising edge; outputs are checked at that same point, away from the edge.
module tb_sfifo_ctrl;

  logic        clk;
  logic        rstn;
  logic        wr;
  logic [15:0] din;
  logic        full;
  logic        afull;
  logic        ovf;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] dout;
  logic [3:0]  count;

  int total;
  int bad;

  sfifo_ctrl dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr       (wr),
    .din      (din),
    .full     (full),
    .afull    (afull),
    .ovf      (ovf),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .dout     (dout),
    .count    (count)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted always, reported only on mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [15:0] d, input logic rdy);
    wr       = w;
    din      = d;
    rd_ready = rdy;
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q[$];
  logic        exp_ovf;
  int          size_pre;

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_full",   32'(full),     32'd0);
    checkOutput("rst_afull",  32'(afull),    32'd0);
    checkOutput("rst_ovf",    32'(ovf),      32'd0);
    checkOutput("rst_valid",  32'(rd_valid), 32'd0);
    checkOutput("rst_count",  32'(count),    32'd0);
    rstn = 1'b1;
    step();

    // Fill with 1..8, no pops: afull from 6, full at 8, head stays 0x0001
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 16'(k), 1'b0);
      step();
      checkOutput("fill_count", 32'(count), 32'(k));
      checkOutput("fill_afull", 32'(afull), (k >= 6) ? 32'd1 : 32'd0);
      checkOutput("fill_full",  32'(full),  (k == 8) ? 32'd1 : 32'd0);
      checkOutput("fill_valid", 32'(rd_valid), 32'd1);
      checkOutput("fill_dout",  32'(dout), 32'h0001);
    end
    checkOutput("fill_ovf", 32'(ovf), 32'd0);

    // Push 0x00AA while full with a same-cycle pop: dropped, ovf sticks
    applyStimulus(1'b1, 16'h00AA, 1'b1);
    step();
    checkOutput("ovf_set",   32'(ovf),   32'd1);
    checkOutput("ovf_count", 32'(count), 32'd7);
    checkOutput("ovf_full",  32'(full),  32'd0);

    // Drain: order 2..8, no 0x00AA
    applyStimulus(1'b0, 16'h0, 1'b1);
    for (int k = 2; k <= 8; k++) begin
      checkOutput("drain_dout", 32'(dout), 32'(k));
      step();
    end
    checkOutput("drain_count", 32'(count),    32'd0);
    checkOutput("drain_valid", 32'(rd_valid), 32'd0);
    checkOutput("drain_afull", 32'(afull),    32'd0);
    checkOutput("drain_ovf",   32'(ovf),      32'd1);

    // Pop on empty is ignored
    step();
    checkOutput("empty_pop_count", 32'(count), 32'd0);

    // Single push latency from empty
    applyStimulus(1'b1, 16'h1234, 1'b0);
    checkOutput("lat_pre_valid", 32'(rd_valid), 32'd0);
    step();
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("lat_valid", 32'(rd_valid), 32'd1);
    checkOutput("lat_dout",  32'(dout),     32'h1234);
    checkOutput("lat_count", 32'(count),    32'd1);
    step();
    checkOutput("hold_dout", 32'(dout), 32'h1234);
    applyStimulus(1'b0, 16'h0, 1'b1);
    step();
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("lat_pop_count", 32'(count),    32'd0);
    checkOutput("lat_pop_valid", 32'(rd_valid), 32'd0);

    // Streaming push+pop for 20 cycles across pointer wraps, count held at 1
    applyStimulus(1'b1, 16'h0100, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 16'(16'h0101 + i), 1'b1);
      checkOutput("stream_dout",  32'(dout),  32'(16'h0100 + i));
      checkOutput("stream_count", 32'(count), 32'd1);
      step();
    end
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("stream_last", 32'(dout), 32'h0114);
    step();
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("stream_end_count", 32'(count), 32'd0);

    // Asynchronous reset mid-stream with 5 words held
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 16'(16'h0500 + k), 1'b0);
      step();
    end
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("pre_rst_count", 32'(count), 32'd5);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("arst_count", 32'(count),    32'd0);
    checkOutput("arst_valid", 32'(rd_valid), 32'd0);
    checkOutput("arst_full",  32'(full),     32'd0);
    checkOutput("arst_afull", 32'(afull),    32'd0);
    checkOutput("arst_ovf",   32'(ovf),      32'd0);
    step();
    rstn = 1'b1;
    step();
    checkOutput("post_rst_valid", 32'(rd_valid), 32'd0);
    checkOutput("post_rst_count", 32'(count),    32'd0);
    applyStimulus(1'b1, 16'h0600, 1'b0);
    step();
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("post_rst_dout", 32'(dout), 32'h0600);
    step();
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("post_rst_empty", 32'(count), 32'd0);

    // Random backpressure against a queue model
    q.delete();
    exp_ovf = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      applyStimulus(($urandom_range(0, 9) < 6), 16'($urandom), ($urandom_range(0, 1) == 1));
      checkOutput("rnd_valid", 32'(rd_valid), (q.size() != 0) ? 32'd1 : 32'd0);
      checkOutput("rnd_count", 32'(count), 32'(q.size()));
      checkOutput("rnd_full",  32'(full),  (q.size() == 8) ? 32'd1 : 32'd0);
      if (q.size() != 0) checkOutput("rnd_dout", 32'(dout), 32'(q[0]));
      size_pre = q.size();
      step();
      if (rd_ready && size_pre != 0) void'(q.pop_front());
      if (wr && size_pre < 8) q.push_back(din);
      if (wr && size_pre == 8) exp_ovf = 1'b1;
    end
    checkOutput("rnd_ovf", 32'(ovf), 32'(exp_ovf));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
